// File: rtl/shift_unit_pipe_if.sv
// Valid/ready bundle for the pipelined barrel shifter.
// Master drives operations in and consumes results.
interface shift_unit_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic [TAG_W-1:0]   tag_in;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   data_out;
  logic [TAG_W-1:0]   tag_out;
  logic [1:0]         mode_out;

  modport master (
    output in_valid, mode, shamt,
    output data_in, tag_in, out_ready,
    input  in_ready, out_valid,
    input  data_out, tag_out, mode_out
  );

  modport slave (
    input  in_valid, mode, shamt,
    input  data_in, tag_in, out_ready,
    output in_ready, out_valid,
    output data_out, tag_out, mode_out
  );
endinterface

// File: rtl/shift_unit_pipe.sv
// Pipelined log barrel shifter: SLL/SRL/SRA/ROR, tag sideband,
// global stall with flush, latency STAGES cycles.
module shift_unit_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STAGES  = 2,
  parameter int TAG_W   = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  shift_unit_pipe_if.slave bus
);

  function automatic logic [WIDTH-1:0] lvl(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       m,
    input logic             sg,
    input int               k
  );
    logic [2*WIDTH-1:0] t;
    t = '0;
    unique case (m)
      2'b00: t[WIDTH-1:0] = d << k;
      2'b01: t[WIDTH-1:0] = d >> k;
      2'b10: t = {{WIDTH{sg}}, d} >> k;
      2'b11: t[WIDTH-1:0] = (d >> k) | (d << (WIDTH - k));
    endcase
    return t[WIDTH-1:0];
  endfunction

  logic stall;
  logic unused_ok;

  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    logic [WIDTH-1:0]   src_d, shifted, d_q;
    logic [SHAMT_W-1:0] src_sh, sh_q;
    logic [1:0]         src_m, m_q;
    logic [TAG_W-1:0]   src_t, t_q;
    logic               src_sg, sg_q;
    logic               src_v, v_q;

    if (s == 0) begin : g_head
      // Sign is sampled once at issue so SRA fill survives all levels.
      assign src_d  = bus.data_in;
      assign src_sh = bus.shamt;
      assign src_m  = bus.mode;
      assign src_t  = bus.tag_in;
      assign src_sg = bus.data_in[WIDTH-1];
      assign src_v  = bus.in_valid;
    end else begin : g_body
      assign src_d  = g_st[s-1].d_q;
      assign src_sh = g_st[s-1].sh_q;
      assign src_m  = g_st[s-1].m_q;
      assign src_t  = g_st[s-1].t_q;
      assign src_sg = g_st[s-1].sg_q;
      assign src_v  = g_st[s-1].v_q;
    end

    always_comb begin
      shifted = src_d;
      for (int i = 0; i < SHAMT_W; i++) begin
        if (((i * STAGES) / SHAMT_W) == s && src_sh[i])
          shifted = lvl(shifted, src_m, src_sg, 1 << i);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        d_q  <= '0;
        sh_q <= '0;
        m_q  <= '0;
        t_q  <= '0;
        sg_q <= 1'b0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (!stall) begin
        v_q  <= src_v;
        d_q  <= shifted;
        sh_q <= src_sh;
        m_q  <= src_m;
        t_q  <= src_t;
        sg_q <= src_sg;
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.data_out  = g_st[STAGES-1].d_q;
  assign bus.tag_out   = g_st[STAGES-1].t_q;
  assign bus.mode_out  = g_st[STAGES-1].m_q;

  assign unused_ok = ^{g_st[STAGES-1].sh_q,
                       g_st[STAGES-1].sg_q};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe with WIDTH=32, STAGES=2.
// Expected values are hand computed.
module tb_shift_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int checks = 0;
  int failures = 0;

  shift_unit_pipe_if #(.WIDTH(32), .SHAMT_W(5), .TAG_W(5)) bus ();

  shift_unit_pipe #(
    .WIDTH(32), .SHAMT_W(5), .STAGES(2), .TAG_W(5)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [4:0] sh,
                       input logic [31:0] d, input logic [4:0] t);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.shamt    = sh;
    bus.data_in  = d;
    bus.tag_in   = t;
  endtask

  task automatic op(input string tag, input logic [1:0] m,
                    input logic [4:0] sh, input logic [31:0] d,
                    input logic [31:0] exp);
    drive(m, sh, d, 5'd3);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
    chk({tag, "_data"}, bus.data_out, exp);
    chk({tag, "_mode"}, {30'd0, bus.mode_out}, {30'd0, m});
    tick();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.mode      = 2'b00;
    bus.shamt     = '0;
    bus.data_in   = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;
    #2;
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_tag", {27'd0, bus.tag_out}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_inready", {31'd0, bus.in_ready}, 32'd1);
    tick();

    op("sll4", 2'b00, 5'd4, 32'h0000_00F1, 32'h0000_0F10);
    op("sra31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
    op("srl31", 2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
    op("ror8", 2'b11, 5'd8, 32'h1234_5678, 32'h7812_3456);
    op("sra_pos", 2'b10, 5'd4, 32'h7000_0000, 32'h0700_0000);
    op("ror1", 2'b11, 5'd1, 32'h0000_0001, 32'h8000_0000);
    op("sll31", 2'b00, 5'd31, 32'h0000_0001, 32'h8000_0000);
    op("sll0", 2'b00, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    op("srl0", 2'b01, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    op("sra0", 2'b10, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);
    op("ror0", 2'b11, 5'd0, 32'hA5A5_0F0F, 32'hA5A5_0F0F);

    begin
      int r = 0;
      for (int c = 0; c < 10; c++) begin
        if (c < 8) drive(2'b00, c[4:0], c + 1, c[4:0]);
        else bus.in_valid = 1'b0;
        tick();
        chk("b2b_valid", {31'd0, bus.out_valid},
            (c >= 1 && c <= 8) ? 32'd1 : 32'd0);
        if (bus.out_valid) begin
          chk("b2b_tag", {27'd0, bus.tag_out}, r);
          chk("b2b_data", bus.data_out, (r + 1) << r);
          r++;
        end
      end
      chk("b2b_count", r, 32'd8);
    end
    bus.in_valid = 1'b0;
    tick();

    bus.out_ready = 1'b0;
    drive(2'b01, 5'd4, 32'hF000_0000, 5'd10);
    tick();
    drive(2'b11, 5'd4, 32'h0000_00FF, 5'd11);
    tick();
    drive(2'b00, 5'd1, 32'h0000_0003, 5'd12);
    chk("bp_inready", {31'd0, bus.in_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_data", bus.data_out, 32'h0F00_0000);
      chk("bp_tag", {27'd0, bus.tag_out}, 32'd10);
      chk("bp_inready_hold", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_b_tag", {27'd0, bus.tag_out}, 32'd11);
    chk("bp_b_data", bus.data_out, 32'hF000_000F);
    tick();
    chk("bp_c_tag", {27'd0, bus.tag_out}, 32'd12);
    chk("bp_c_data", bus.data_out, 32'h0000_0006);
    tick();
    chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);

    drive(2'b00, 5'd1, 32'h1, 5'd20);
    tick();
    drive(2'b00, 5'd2, 32'h1, 5'd21);
    tick();
    drive(2'b00, 5'd3, 32'h1, 5'd22);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
      tick();
    end

    bus.out_ready = 1'b0;
    drive(2'b00, 5'd1, 32'h1, 5'd23);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("fstall_pre", {31'd0, bus.out_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fstall_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fstall_inready", {31'd0, bus.in_ready}, 32'd1);

    drive(2'b11, 5'd4, 32'h1234_5678, 5'd9);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("arst_pre", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_data", bus.data_out, 32'd0);
    chk("arst_tag", {27'd0, bus.tag_out}, 32'd0);
    chk("arst_mode", {30'd0, bus.mode_out}, 32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_inready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    chk("arst_noout", {31'd0, bus.out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
